// File: rtl/child_dispatch_sched.sv
// child_dispatch_sched: round-robin dispatcher of tagged jobs to NUM_CHILD
// child units over a start/done handshake, reporting one completion per cycle.
// Ports: clk, rst (sync, active-high); job_valid/job_ready/job_tag upstream;
//   child_start/child_tag/child_done to children; cmp_valid/cmp_child/
//   cmp_tag/cmp_err completion report; busy_mask, idle status.
// Optional watchdog: define CHILD_SCHED_WATCHDOG_EN to build per-child
//   busy counters that force a completion with cmp_err after TIMEOUT cycles.
module child_dispatch_sched #(
    parameter int NUM_CHILD = 5,
    parameter int TAG_W     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [TAG_W-1:0]     job_tag,
    output logic [NUM_CHILD-1:0] child_start,
    output logic [TAG_W-1:0]     child_tag,
    input  logic [NUM_CHILD-1:0] child_done,
    output logic                 cmp_valid,
    output logic [2:0]           cmp_child,
    output logic [TAG_W-1:0]     cmp_tag,
    output logic                 cmp_err,
    output logic [NUM_CHILD-1:0] busy_mask,
    output logic                 idle
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    logic [1:0]           st_q [NUM_CHILD];
    logic [1:0]           st_d [NUM_CHILD];
    logic [TAG_W-1:0]     tag_q [NUM_CHILD];
    logic [2:0]           rr_ptr;
    logic [2:0]           tgt;
    logic                 tgt_ok;
    logic [2:0]           rep_idx;
    logic                 rep_ok;
    logic                 disp;
    logic [3:0]           scan;
    logic [NUM_CHILD-1:0] expire;

    // First IDLE child at or above rr_ptr (with wrap). Scanning from the far
    // end and overwriting lets the nearest candidate win without a flag.
    always_comb begin
        tgt    = '0;
        tgt_ok = 1'b0;
        scan   = '0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + 4'(k);
            if (scan >= 4'(NUM_CHILD))
                scan = scan - 4'(NUM_CHILD);
            if (st_q[scan[2:0]] == S_IDLE) begin
                tgt    = scan[2:0];
                tgt_ok = 1'b1;
            end
        end
    end

    // Lowest-index PEND child is reported this cycle.
    always_comb begin
        rep_idx = '0;
        rep_ok  = 1'b0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            if (st_q[k] == S_PEND) begin
                rep_idx = 3'(k);
                rep_ok  = 1'b1;
            end
        end
    end

    assign disp = job_valid & tgt_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHILD; i++)
                st_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CHILD; i++)
                st_q[i] <= st_d[i];
        end
    end

    // Next-state logic; child_done only counts while BUSY and wins over expiry
    always_comb begin
        for (int i = 0; i < NUM_CHILD; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                S_IDLE: if (disp && tgt == 3'(i)) st_d[i] = S_BUSY;
                S_BUSY: if (child_done[i] || expire[i]) st_d[i] = S_PEND;
                S_PEND: if (rep_ok && rep_idx == 3'(i)) st_d[i] = S_IDLE;
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    // Dispatch datapath: start pulse, tag capture, round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            child_start <= '0;
            child_tag   <= '0;
            for (int i = 0; i < NUM_CHILD; i++)
                tag_q[i] <= '0;
        end else begin
            child_start <= '0;
            child_tag   <= '0;
            if (disp) begin
                child_start <= {{(NUM_CHILD-1){1'b0}}, 1'b1} << tgt;
                child_tag   <= job_tag;
                tag_q[tgt]  <= job_tag;
                rr_ptr      <= (tgt == 3'(NUM_CHILD - 1)) ? 3'd0 : tgt + 3'd1;
            end
        end
    end

`ifdef CHILD_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]        cnt_q [NUM_CHILD];
    logic [NUM_CHILD-1:0] err_q;

    always_comb begin
        for (int i = 0; i < NUM_CHILD; i++)
            expire[i] = (st_q[i] == S_BUSY) && (cnt_q[i] == CW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            for (int i = 0; i < NUM_CHILD; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHILD; i++) begin
                if (st_q[i] == S_IDLE && st_d[i] == S_BUSY)
                    cnt_q[i] <= '0;
                else if (st_q[i] == S_BUSY)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                if (st_q[i] == S_BUSY && st_d[i] == S_PEND)
                    err_q[i] <= ~child_done[i];
            end
        end
    end
`else
    assign expire = '0;
`endif

    // Outputs
    always_comb begin
        job_ready = 1'b0;
        busy_mask = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            busy_mask[i] = (st_q[i] != S_IDLE);
            if (st_q[i] == S_IDLE)
                job_ready = 1'b1;
        end
        idle      = ~|busy_mask;
        cmp_valid = rep_ok;
        cmp_child = rep_ok ? rep_idx : 3'd0;
        cmp_tag   = rep_ok ? tag_q[rep_idx] : '0;
`ifdef CHILD_SCHED_WATCHDOG_EN
        cmp_err   = rep_ok & err_q[rep_idx];
`else
        cmp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_child_dispatch_sched.sv
// tb_child_dispatch_sched: directed self-checking bench for the
// round-robin child scheduler.
module tb_child_dispatch_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_tag;
    logic [4:0] child_start;
    logic [7:0] child_tag;
    logic [4:0] child_done;
    logic       cmp_valid;
    logic [2:0] cmp_child;
    logic [7:0] cmp_tag;
    logic       cmp_err;
    logic [4:0] busy_mask;
    logic       idle;

    int checks = 0;
    int failures = 0;

    child_dispatch_sched #(
        .NUM_CHILD(5),
        .TAG_W(8),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_tag(job_tag),
        .child_start(child_start),
        .child_tag(child_tag),
        .child_done(child_done),
        .cmp_valid(cmp_valid),
        .cmp_child(cmp_child),
        .cmp_tag(cmp_tag),
        .cmp_err(cmp_err),
        .busy_mask(busy_mask),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        job_valid  = 1'b0;
        job_tag    = 8'h00;
        child_done = 5'b0;
        do_reset();
        checks++;
        if ({job_ready, child_start, child_tag, cmp_valid, cmp_child,
             cmp_tag, cmp_err, busy_mask, idle} !==
            {1'b1, 5'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 5'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset: ready=%b start=%b tag=%h cv=%b cc=%0d ct=%h ce=%b busy=%b idle=%b",
                     job_ready, child_start, child_tag, cmp_valid, cmp_child,
                     cmp_tag, cmp_err, busy_mask, idle);
        end
    endtask

    task automatic test_back_to_back();
        job_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            job_tag = 8'h10 + 8'(i);
            tick();
            checks++;
            if (child_start !== (5'b1 << i) || child_tag !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL b2b_start[%0d]: start=%b tag=%h want %b %h",
                         i, child_start, child_tag, 5'b1 << i, 8'h10 + 8'(i));
            end
        end
        checks++;
        if (job_ready !== 1'b0 || busy_mask !== 5'b11111) begin
            failures++;
            $display("FAIL b2b_full: ready=%b busy=%b want 0 11111",
                     job_ready, busy_mask);
        end
        job_valid = 1'b0;
        tick();
        checks++;
        if (child_start !== 5'b0 || idle !== 1'b0) begin
            failures++;
            $display("FAIL b2b_quiet: start=%b idle=%b want 00000 0",
                     child_start, idle);
        end
    endtask

    task automatic test_single_done();
        child_done = 5'b00100;
        tick();
        child_done = 5'b0;
        checks++;
        if ({cmp_valid, cmp_child, cmp_tag, cmp_err, job_ready} !==
            {1'b1, 3'd2, 8'h12, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_report: cv=%b cc=%0d ct=%h ce=%b ready=%b want 1 2 12 0 0",
                     cmp_valid, cmp_child, cmp_tag, cmp_err, job_ready);
        end
        tick();
        checks++;
        if (cmp_valid !== 1'b0 || job_ready !== 1'b1 || busy_mask !== 5'b11011) begin
            failures++;
            $display("FAIL single_reuse: cv=%b ready=%b busy=%b want 0 1 11011",
                     cmp_valid, job_ready, busy_mask);
        end
        // rr_ptr is 0, only child 2 free: refill it with its old tag
        job_valid = 1'b1;
        job_tag   = 8'h12;
        tick();
        job_valid = 1'b0;
        checks++;
        if (child_start !== 5'b00100 || job_ready !== 1'b0) begin
            failures++;
            $display("FAIL refill: start=%b ready=%b want 00100 0",
                     child_start, job_ready);
        end
    endtask

    task automatic test_all_done();
        child_done = 5'b11111;
        tick();
        child_done = 5'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({cmp_valid, cmp_child, cmp_tag, cmp_err} !==
                {1'b1, 3'(k), 8'h10 + 8'(k), 1'b0}) begin
                failures++;
                $display("FAIL all_report[%0d]: cv=%b cc=%0d ct=%h ce=%b want 1 %0d %h 0",
                         k, cmp_valid, cmp_child, cmp_tag, cmp_err, k, 8'h10 + 8'(k));
            end
            tick();
        end
        checks++;
        if (cmp_valid !== 1'b0 || idle !== 1'b1 || busy_mask !== 5'b0) begin
            failures++;
            $display("FAIL all_idle: cv=%b idle=%b busy=%b want 0 1 00000",
                     cmp_valid, idle, busy_mask);
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        job_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            job_tag = 8'h20 + 8'(i);
            tick();
        end
        job_valid  = 1'b0;
        child_done = 5'b00001;
        tick();
        child_done = 5'b0;
        tick();
        checks++;
        if (busy_mask !== 5'b01110) begin
            failures++;
            $display("FAIL rr_free: busy=%b want 01110", busy_mask);
        end
        job_valid = 1'b1;
        job_tag   = 8'h24;
        tick();
        checks++;
        if (child_start !== 5'b10000 || child_tag !== 8'h24) begin
            failures++;
            $display("FAIL rr_to4: start=%b tag=%h want 10000 24",
                     child_start, child_tag);
        end
        job_tag = 8'h25;
        tick();
        job_valid = 1'b0;
        checks++;
        if (child_start !== 5'b00001 || child_tag !== 8'h25 || job_ready !== 1'b0) begin
            failures++;
            $display("FAIL rr_wrap0: start=%b tag=%h ready=%b want 00001 25 0",
                     child_start, child_tag, job_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        job_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            job_tag = 8'h30 + 8'(i);
            tick();
        end
        job_valid = 1'b0;
        checks++;
        if (busy_mask !== 5'b00111) begin
            failures++;
            $display("FAIL mid_busy: busy=%b want 00111", busy_mask);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy_mask !== 5'b0 || idle !== 1'b1 || child_start !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b idle=%b start=%b want 00000 1 00000",
                     busy_mask, idle, child_start);
        end
        child_done = 5'b00010;
        tick();
        child_done = 5'b0;
        checks++;
        if (cmp_valid !== 1'b0 || busy_mask !== 5'b0) begin
            failures++;
            $display("FAIL stale_done: cv=%b busy=%b want 0 00000",
                     cmp_valid, busy_mask);
        end
        job_valid = 1'b1;
        job_tag   = 8'h33;
        tick();
        job_valid = 1'b0;
        checks++;
        if (child_start !== 5'b00001 || child_tag !== 8'h33) begin
            failures++;
            $display("FAIL post_reset_disp: start=%b tag=%h want 00001 33",
                     child_start, child_tag);
        end
    endtask

`ifdef CHILD_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        job_valid = 1'b1;
        job_tag   = 8'h40;
        tick();
        job_valid = 1'b0;
        // now in the start cycle; error report lands 9 cycles later
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c < 9) begin
                checks++;
                if (cmp_valid !== 1'b0 || busy_mask !== 5'b00001) begin
                    failures++;
                    $display("FAIL wd_wait[%0d]: cv=%b busy=%b want 0 00001",
                             c, cmp_valid, busy_mask);
                end
            end
        end
        checks++;
        if ({cmp_valid, cmp_child, cmp_tag, cmp_err} !==
            {1'b1, 3'd0, 8'h40, 1'b1}) begin
            failures++;
            $display("FAIL wd_report: cv=%b cc=%0d ct=%h ce=%b want 1 0 40 1",
                     cmp_valid, cmp_child, cmp_tag, cmp_err);
        end
        tick();
        child_done = 5'b00001;
        tick();
        child_done = 5'b0;
        checks++;
        if (cmp_valid !== 1'b0 || busy_mask !== 5'b0) begin
            failures++;
            $display("FAIL wd_late_done: cv=%b busy=%b want 0 00000",
                     cmp_valid, busy_mask);
        end
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        job_valid = 1'b1;
        job_tag   = 8'h40;
        tick();
        job_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (cmp_valid !== 1'b0 || busy_mask !== 5'b00001) begin
                failures++;
                $display("FAIL nowd_busy[%0d]: cv=%b busy=%b want 0 00001",
                         c, cmp_valid, busy_mask);
            end
        end
        child_done = 5'b00001;
        tick();
        child_done = 5'b0;
        checks++;
        if ({cmp_valid, cmp_child, cmp_tag, cmp_err} !==
            {1'b1, 3'd0, 8'h40, 1'b0}) begin
            failures++;
            $display("FAIL nowd_report: cv=%b cc=%0d ct=%h ce=%b want 1 0 40 0",
                     cmp_valid, cmp_child, cmp_tag, cmp_err);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_tag    = 8'h00;
        child_done = 5'b0;
        test_reset();
        test_back_to_back();
        test_single_done();
        test_all_done();
        test_rr_wrap();
        test_reset_mid_op();
`ifdef CHILD_SCHED_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
